// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder (PHY side): oversamples MDC/MDIO on clk,
// decodes frames addressed to PHY_ADDR, strobes register writes and serves reads.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        rd_req,
    input  logic [15:0] rd_data_in,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_LEN);

    logic        mdc_s1_q, mdc_s2_q, mdc_h_q;
    logic        mdio_s1_q, mdio_s2_q, mdio_h_q;
    logic [1:0]  mask_q;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  ones_q, ones_d;
    logic [15:0] sh_q, sh_d;
    logic        op_rd_q, op_rd_d;
    logic        phy_ok_q, phy_ok_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_req_q, rd_req_d;
    logic        rd_d1_q, rd_d1_d;
    logic        rd_d2_q, rd_d2_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        frame_err_q, frame_err_d;

    logic rise, fall, sample;

    assign rise   = (mask_q == 2'd3) && mdc_s2_q && !mdc_h_q;
    assign fall   = (mask_q == 2'd3) && !mdc_s2_q && mdc_h_q;
    // MDIO as it stood one clk before the detected MDC edge: extra setup margin.
    assign sample = mdio_h_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mdc_s1_q  <= 1'b0;
            mdc_s2_q  <= 1'b0;
            mdc_h_q   <= 1'b0;
            mdio_s1_q <= 1'b0;
            mdio_s2_q <= 1'b0;
            mdio_h_q  <= 1'b0;
            mask_q    <= '0;
        end else begin
            mdc_s1_q  <= mdc;
            mdc_s2_q  <= mdc_s1_q;
            mdc_h_q   <= mdc_s2_q;
            mdio_s1_q <= mdio_in;
            mdio_s2_q <= mdio_s1_q;
            mdio_h_q  <= mdio_s2_q;
            if (mask_q != 2'd3) mask_q <= mask_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            sh_q        <= '0;
            op_rd_q     <= 1'b0;
            phy_ok_q    <= 1'b0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_d1_q     <= 1'b0;
            rd_d2_q     <= 1'b0;
            rd_sh_q     <= '0;
            mdio_out_q  <= 1'b0;
            mdio_oe_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            sh_q        <= sh_d;
            op_rd_q     <= op_rd_d;
            phy_ok_q    <= phy_ok_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            wr_stb_q    <= wr_stb_d;
            rd_req_q    <= rd_req_d;
            rd_d1_q     <= rd_d1_d;
            rd_d2_q     <= rd_d2_d;
            rd_sh_q     <= rd_sh_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_q   <= mdio_oe_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        sh_d        = sh_q;
        op_rd_d     = op_rd_q;
        phy_ok_d    = phy_ok_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        wr_stb_d    = 1'b0;
        rd_req_d    = 1'b0;
        rd_d1_d     = rd_req_q;
        rd_d2_d     = rd_d1_q;
        rd_sh_d     = rd_sh_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_d   = mdio_oe_q;
        frame_err_d = 1'b0;

        // Register bank answers two clk after rd_req.
        if (rd_d2_q) rd_sh_d = rd_data_in;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    if (sample) begin
                        if (ones_q != 6'd63) ones_d = ones_q + 6'd1;
                    end else if (ones_q >= PRE_MIN) begin
                        state_d = S_ST;
                        ones_d  = '0;
                    end else begin
                        ones_d = '0;
                    end
                end
            end
            S_ST: begin
                if (rise) begin
                    bit_cnt_d = '0;
                    if (sample) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_OP: begin
                if (rise) begin
                    sh_d = {sh_q[14:0], sample};
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        case ({sh_q[0], sample})
                            2'b01: begin
                                op_rd_d = 1'b0;
                                state_d = S_PHYAD;
                            end
                            2'b10: begin
                                op_rd_d = 1'b1;
                                state_d = S_PHYAD;
                            end
                            default: begin
                                frame_err_d = 1'b1;
                                state_d     = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            S_PHYAD: begin
                if (rise) begin
                    sh_d = {sh_q[14:0], sample};
                    if (bit_cnt_q == 5'd4) begin
                        phy_ok_d  = ({sh_q[3:0], sample} == PHY_ADDR);
                        bit_cnt_d = '0;
                        state_d   = S_REGAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_REGAD: begin
                if (rise) begin
                    sh_d = {sh_q[14:0], sample};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        if (!phy_ok_q) begin
                            state_d = S_IDLE;
                        end else begin
                            reg_addr_d = {sh_q[3:0], sample};
                            if (op_rd_q) begin
                                rd_req_d = 1'b1;
                                state_d  = S_RDATA;
                            end else begin
                                state_d = S_TA;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_TA: begin
                if (rise) begin
                    if (bit_cnt_q == 5'd0 && sample) begin
                        bit_cnt_d = 5'd1;
                    end else if (bit_cnt_q == 5'd1 && !sample) begin
                        bit_cnt_d = '0;
                        state_d   = S_WDATA;
                    end else begin
                        bit_cnt_d   = '0;
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    sh_d = {sh_q[14:0], sample};
                    if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d = '0;
                        wr_data_d = {sh_q[14:0], sample};
                        wr_stb_d  = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_RDATA: begin
                // bit_cnt counts falls already seen: 0 = TA1, 1 = TA2, 2..17 = data, 18 = release.
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                    end else if (bit_cnt_q >= 5'd2 && bit_cnt_q <= 5'd17) begin
                        mdio_out_d = rd_sh_q[15];
                        rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                    end else if (bit_cnt_q == 5'd18) begin
                        mdio_oe_d  = 1'b0;
                        mdio_out_d = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_stb    = wr_stb_q;
    assign rd_req    = rd_req_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a station-controller model drives MDC/MDIO
// frames and a two-clk-latency register bank answers read requests.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdio_out, mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] wr_data;
    logic        wr_stb, rd_req;
    logic [15:0] rd_data_in = 16'hDEAD;
    logic        busy, frame_err;

    mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
        .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
        .wr_data(wr_data), .wr_stb(wr_stb), .rd_req(rd_req),
        .rd_data_in(rd_data_in), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic oe_seen = 1'b0;
    wr_t wr_q[$];
    wr_t wr_e;
    logic [4:0] rd_q[$];
    logic [4:0] rd_e;
    logic [1:0] rdbit_q[$];
    logic [15:0] bank [32];
    logic rd_p1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register bank with two clk of read latency; garbage outside the valid cycle.
    always @(posedge clk) begin
        rd_p1 <= rd_req;
        if (rd_p1) rd_data_in <= bank[reg_addr];
        else       rd_data_in <= 16'hDEAD;
    end

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (mdio_oe) oe_seen = 1'b1;
        if (wr_stb) begin
            if (wr_q.size() == 0) begin
                check("wr_stb_unexpected", 32'(wr_stb), 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(wr_e.a));
                check("wr_data", 32'(wr_data), 32'(wr_e.d));
            end
        end
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                check("rd_req_unexpected", 32'(rd_req), 32'd0);
            end else begin
                rd_e = rd_q.pop_front();
                check("rd_addr", 32'(reg_addr), 32'(rd_e));
            end
        end
    end

    task automatic send_bit(input logic b);
        mdio_in = b;
        repeat (5) @(negedge clk);
        mdc = 1'b1;
        repeat (5) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] d, input int pre);
        wr_t e;
        if (phy == 5'd1 && pre >= 32) begin
            e.a = ra;
            e.d = d;
            wr_q.push_back(e);
        end
        preamble(pre);
        send_bits({32'd0, 2'b01, 2'b01, phy, ra, 2'b10, d}, 32);
    endtask

    task automatic do_read(input logic [4:0] ra, input int abort_k);
        logic [15:0] d;
        logic aborted;
        d = bank[ra];
        rd_q.push_back(ra);
        rdbit_q.push_back(2'b00);
        rdbit_q.push_back(2'b10);
        for (int i = 15; i >= 0; i--) rdbit_q.push_back({1'b1, d[i]});
        preamble(32);
        send_bits({50'd0, 2'b01, 2'b10, 5'd1, ra}, 14);
        mdio_in = 1'b1;
        aborted = 1'b0;
        for (int k = 1; k <= 18 && !aborted; k++) begin
            repeat (5) @(negedge clk);
            check("rd_pin", 32'({mdio_oe, mdio_out}), 32'(rdbit_q.pop_front()));
            if (k == 2) check("rd_busy", 32'(busy), 32'd1);
            if (k == abort_k) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_outs", 32'({mdio_out, mdio_oe, reg_addr, wr_data,
                                          wr_stb, rd_req, busy, frame_err}), 32'd0);
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                mdc = 1'b1;
                repeat (5) @(negedge clk);
                mdc = 1'b0;
            end
        end
        if (!aborted) begin
            repeat (5) @(negedge clk);
            check("rd_release", 32'({busy, mdio_oe, mdio_out}), 32'd0);
        end
        rdbit_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 16'(i * 16'h0101);
        bank[3]  = 16'h1234;
        bank[9]  = 16'hBEEF;

        repeat (4) @(negedge clk);
        check("reset_outs", 32'({mdio_out, mdio_oe, reg_addr, wr_data,
                                  wr_stb, rd_req, busy, frame_err}), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        oe_seen = 1'b0;
        do_write(5'd1, 5'd5, 16'hA5C3, 32);
        check("write_oe_idle", 32'(oe_seen), 32'd0);
        check("write_no_err", 32'(err_cnt), 32'd0);

        do_read(5'd3, 0);

        oe_seen = 1'b0;
        do_write(5'd2, 5'd6, 16'hFFFF, 32);
        do_write(5'd1, 5'd7, 16'h0F0F, 32);
        check("phy_mismatch_err", 32'(err_cnt), 32'd0);
        check("phy_mismatch_oe", 32'(oe_seen), 32'd0);

        do_write(5'd1, 5'd4, 16'h1111, 31);
        do_write(5'd1, 5'd4, 16'h2222, 32);
        check("preamble_err", 32'(err_cnt), 32'd0);

        preamble(32);
        send_bits(64'b00, 2);
        repeat (4) @(negedge clk);
        check("bad_st_err", 32'(err_cnt), 32'd1);

        preamble(32);
        send_bits(64'b0111, 4);
        repeat (4) @(negedge clk);
        check("bad_op_err", 32'(err_cnt), 32'd2);

        preamble(32);
        send_bits(64'b01_01_00001_00101_11, 16);
        repeat (4) @(negedge clk);
        check("bad_ta_err", 32'(err_cnt), 32'd3);

        do_read(5'd3, 11);
        do_read(5'd9, 0);
        do_write(5'd1, 5'd31, 16'h8001, 32);
        repeat (10) @(negedge clk);

        check("final_err", 32'(err_cnt), 32'd3);
        check("wr_pending", 32'(wr_q.size()), 32'd0);
        check("rd_pending", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side Clause-22 MDIO management responder.
- Oversamples MDC/MDIO from the station controller on the local clk and decodes write and read frames addressed to PHY_ADDR.
- Writes are presented on a one-cycle register-write strobe.
- Reads fetch 16 bits from the local register bank and shift them back on mdio_out.
- Sits between the MDIO pins and the PHY register file.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PREAMBLE_LEN, 32, minimum consecutive 1 bits accepted as preamble (1..63).

Ports:
- clk  input  1  system clock; MDC period must be ≥8 clk, each MDC phase ≥4 clk.
- reset  input  1  synchronous, active-low reset.
- mdc  input  1  management clock from the controller, asynchronous to clk.
- mdio_in  input  1  serial data from the controller, asynchronous to clk.
- mdio_out  output  1  serial read data/TA driven to the controller.
- mdio_oe  output  1  1 = responder drives the MDIO line.
- reg_addr  output  5  REGAD of the current frame.
- wr_data  output  16  write data, valid while wr_stb=1.
- wr_stb  output  1  one-clk pulse, register write.
- rd_req  output  1  one-clk pulse, register read request.
- rd_data_in  input  16  read data from the register bank, valid 2 clk after rd_req.
- busy  output  1  1 from the ST decode until the frame ends or aborts.
- frame_err  output  1  one-clk pulse on a malformed frame (bad ST, OP 00/11, bad write TA).

Behaviour:
- Reset (reset=0 at posedge clk): all outputs 0, state IDLE, preamble counter 0, shift registers 0. Reset mid-frame aborts immediately; mdio_oe drops on the next clk edge.
- Sync/edges:
  - mdc and mdio_in each pass through 2 synchronizer flops plus 1 history flop.
  - rise = sync=1 and history=0; fall = sync=0 and history=1.
  - Edge detection is masked for the first 3 clk after reset deassertion, so no spurious edge occurs.
- Sampling and driving: mdio_in is sampled only on rise; mdio_out/mdio_oe update on the clk after a fall is detected (registered).
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA. Bit counter 5 bits.
- IDLE:
  - 1 sampled: ones counter increments, saturating at 63.
  - 0 sampled with count ≥ PREAMBLE_LEN: taken as ST bit 0; go to ST.
  - 0 sampled otherwise: counter cleared.
- ST: expects 1 -> OP; otherwise frame_err, back to IDLE.
- OP: 2 bits. 01 = write, 10 = read, else frame_err -> IDLE.
- PHYAD: 5 bits, MSB first.
- REGAD: 5 bits, MSB first; reg_addr loaded after the 5th bit.
  - PHYAD≠PHY_ADDR: silent return to IDLE; no strobes, no drive, no frame_err.
- Write path:
  - TA must sample 1 then 0, else frame_err -> IDLE.
  - WDATA shifts in 16 bits MSB first.
  - After the 16th rise: wr_stb=1 for exactly 1 clk with wr_data and reg_addr stable; then IDLE.
- Read path:
  - rd_req pulses 1 clk, one clk after the REGAD final rise.
  - rd_data_in is latched into the output shift register 2 clk after rd_req.
  - TA bit 1 (first fall after REGAD): mdio_oe stays 0.
  - TA bit 2 (second fall): mdio_oe=1, mdio_out=0.
  - Falls 3..18: mdio_out = data[15]..data[0].
  - Fall 19: mdio_oe=0, mdio_out=0, busy=0, back to IDLE.
  - Rises during the read are ignored.
- Counters: the preamble counter is cleared on every exit from IDLE, so a new frame always needs a full preamble.
- Back-to-back frames are supported with no gap beyond the preamble.

Test Plan:
- Write: 32×1, 01, 01, PHYAD=00001, REGAD=00101, TA 10, data 0xA5C3 -> one wr_stb pulse, reg_addr=5, wr_data=0xA5C3; mdio_oe stays 0 throughout.
- Read: preamble, 01 10 00001 00011, rd_data_in=0x1234 -> single rd_req with reg_addr=3; mdio_oe rises at TA2 fall with out=0; out bits 0001001000110100 on next 16 falls; oe=0 at 19th fall.
- Wrong PHYAD=00010 write of 0xFFFF -> no wr_stb, no frame_err; immediately following valid write to PHY 1 is accepted.
- Short preamble (31 ones) then valid frame body -> ignored; 32 ones accepted. OP=11 after valid preamble -> frame_err pulse, no strobes.
- Reset asserted at read data bit 7 -> mdio_oe=0 next clk, outputs all 0; next full frame decodes correctly.
